mw_writeback_stage: RTL and testbench
=====================================

// Module: mw_writeback_stage
// PURPOSE
//  M/W pipeline register plus write-back datapath of the 5-stage MIPS core.
//  Captures memory-stage results, aligns/extends load data, selects the write-back
//  value and drives the register-file write port (wpc_w/a3_w/regwr_w/wd_w).
//  The same a3_w/regwr_w/wd_w also feed the W->D/E forwarding muxes.
//  Keeps a retired-instruction counter.
// PARAMETERS
//  PC_RESET   32'h0000_3000  value of wpc_w after reset/clear
//  CNT_W      32             width of retire_cnt
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      synchronous, active-high
//  en          in   1      1: capture M-stage fields this edge; 0: hold
//  clr         in   1      1: load a bubble this edge
//  valid_m     in   1      M-stage slot holds a real instruction
//  pc_m        in   32     PC of M-stage instruction
//  a3_m        in   5      destination register
//  regwr_m     in   1      instruction writes a register
//  wdsel_m     in   2      00 ALU, 01 memory, 10 link (pc+8), 11 ALU
//  ldop_m      in   3      000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh, others = lw
//  alu_m       in   32     ALU result / effective address
//  dmrd_m      in   32     aligned word read from data memory
//  wpc_w       out  32     PC of W-stage instruction
//  a3_w        out  5      register-file write address
//  regwr_w     out  1      register-file write enable
//  wd_w        out  32     register-file write data
//  valid_w     out  1      W-stage slot holds a real instruction
//  retire_cnt  out  CNT_W  count of valid instructions that entered W
// BEHAVIOUR
//  - Priority per edge: reset > clr > en > hold.
//  - reset/clr: valid_w=0, regwr_w=0, a3_w=0, wpc_w=PC_RESET, stored alu/dm/sel/ldop=0 -> wd_w=0.
//    reset also zeroes retire_cnt; clr does not touch it.
//  - en=1: all M fields registered; latency 1 cycle from M inputs to W outputs.
//  - regwr_w registered as regwr_m & valid_m & (a3_m!=0); $0 write never asserted.
//  - a3_w registered as 0 when that regwr term is 0, so forwarding never matches a dead write.
//  - wd_w combinational from registered fields only (no M input feeds wd_w directly):
//      sel 00/11 -> alu_w; sel 10 -> wpc_w + 8 (mod 2^32); sel 01 -> load result.
//  - Load alignment uses registered alu_w[1:0]:
//      lw: dm_w as is, offset ignored.
//      lbu/lb: byte = dm_w[8*off +: 8]; lbu zero-extends, lb sign-extends bit 7.
//      lhu/lh: half = alu_w[1] ? dm_w[31:16] : dm_w[15:0]; alu_w[0] ignored;
//        lhu zero-extends, lh sign-extends bit 15.
//  - en=0 and clr=0: every register holds; wd_w stable; no double retire.
//  - retire_cnt: +1 on each edge with en=1, clr=0, reset=0, valid_m=1;
//    wraps 2^CNT_W-1 -> 0.
//  - reset mid-stream: next cycle outputs equal reset values regardless of en/clr.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: counter present as above.
//  Undefined: no counter register; retire_cnt tied to 0; all other behaviour identical.
// TESTING
//  1 reset=1 one edge -> regwr_w=0, a3_w=0, wd_w=0, wpc_w=32'h3000, valid_w=0, retire_cnt=0.
//  2 en=1, valid_m=1, regwr_m=1, a3_m=8, wdsel_m=00, alu_m=32'hDEAD_BEEF
//    -> next cycle a3_w=8, regwr_w=1, wd_w=32'hDEAD_BEEF, retire_cnt=1.
//  3 dmrd_m=32'h80FF_7F01, wdsel_m=01, alu_m[1:0] swept 0..3, lb
//    -> wd_w=0000_0001, 0000_007F, FFFF_FFFF, FFFF_FF80.
//  4 same word, lh at alu_m=..2 -> FFFF_80FF; lhu at ..0 -> 0000_7F01.
//  5 jal: pc_m=32'h3010, wdsel_m=10, a3_m=31 -> wd_w=32'h3018.
//  6 a3_m=0 with regwr_m=1 -> regwr_w=0, a3_w=0.
//  7 en=0 for 3 cycles -> outputs and retire_cnt frozen.
//  8 en=1 with clr=1 -> bubble, retire_cnt unchanged.
//  9 preload counter to 2^32-1 (force), one valid retire -> retire_cnt=0.

Source files
------------

// File: rtl/mw_writeback_stage.sv
// M/W pipeline register and write-back datapath: load alignment, write-back select, retire counter.
// Define WB_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retire_cnt reads 0.
module mw_writeback_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             valid_m,
  input  logic [31:0]      pc_m,
  input  logic [4:0]       a3_m,
  input  logic             regwr_m,
  input  logic [1:0]       wdsel_m,
  input  logic [2:0]       ldop_m,
  input  logic [31:0]      alu_m,
  input  logic [31:0]      dmrd_m,
  output logic [31:0]      wpc_w,
  output logic [4:0]       a3_w,
  output logic             regwr_w,
  output logic [31:0]      wd_w,
  output logic             valid_w,
  output logic [CNT_W-1:0] retire_cnt
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  a3_q, a3_d;
  logic        regwr_q, regwr_d;
  logic [1:0]  wdSel_q, wdSel_d;
  logic [2:0]  ldOp_q, ldOp_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] dm_q, dm_d;
  logic        liveWrite;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;

  // A write to $0 or from a dead slot is squashed here so the forwarding
  // comparators downstream never see a matching destination for it.
  assign liveWrite = regwr_m & valid_m & (a3_m != 5'd0);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    a3_d    = a3_q;
    regwr_d = regwr_q;
    wdSel_d = wdSel_q;
    ldOp_d  = ldOp_q;
    alu_d   = alu_q;
    dm_d    = dm_q;
    if (clr) begin
      valid_d = 1'b0;
      pc_d    = PC_RESET;
      a3_d    = 5'd0;
      regwr_d = 1'b0;
      wdSel_d = 2'b00;
      ldOp_d  = 3'b000;
      alu_d   = 32'd0;
      dm_d    = 32'd0;
    end else if (en) begin
      valid_d = valid_m;
      pc_d    = pc_m;
      a3_d    = liveWrite ? a3_m : 5'd0;
      regwr_d = liveWrite;
      wdSel_d = wdsel_m;
      ldOp_d  = ldop_m;
      alu_d   = alu_m;
      dm_d    = dmrd_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= PC_RESET;
      a3_q    <= 5'd0;
      regwr_q <= 1'b0;
      wdSel_q <= 2'b00;
      ldOp_q  <= 3'b000;
      alu_q   <= 32'd0;
      dm_q    <= 32'd0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      a3_q    <= a3_d;
      regwr_q <= regwr_d;
      wdSel_q <= wdSel_d;
      ldOp_q  <= ldOp_d;
      alu_q   <= alu_d;
      dm_q    <= dm_d;
    end
  end

  // Sub-word loads pick their lane from the registered effective address.
  always_comb begin
    loadByte = dm_q[7:0];
    case (alu_q[1:0])
      2'd0: loadByte = dm_q[7:0];
      2'd1: loadByte = dm_q[15:8];
      2'd2: loadByte = dm_q[23:16];
      2'd3: loadByte = dm_q[31:24];
      default: loadByte = dm_q[7:0];
    endcase
    loadHalf = alu_q[1] ? dm_q[31:16] : dm_q[15:0];
    case (ldOp_q)
      3'b001:  loadData = {24'd0, loadByte};
      3'b010:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b011:  loadData = {16'd0, loadHalf};
      3'b100:  loadData = {{16{loadHalf[15]}}, loadHalf};
      default: loadData = dm_q;
    endcase
  end

  always_comb begin
    case (wdSel_q)
      2'b01:   wd_w = loadData;
      2'b10:   wd_w = pc_q + 32'd8;
      default: wd_w = alu_q;
    endcase
  end

  assign wpc_w   = pc_q;
  assign a3_w    = a3_q;
  assign regwr_w = regwr_q;
  assign valid_w = valid_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && !clr && valid_m) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Scoreboard bench for mw_writeback_stage: directed vectors push expectations, a negedge monitor checks them.
// Counter expectations follow WB_RETIRE_CNT_EN the same way the design build does.
module tb_mw_writeback_stage;

  logic        clk;
  logic        reset;
  logic        en;
  logic        clr;
  logic        validM;
  logic [31:0] pcM;
  logic [4:0]  a3M;
  logic        regwrM;
  logic [1:0]  wdselM;
  logic [2:0]  ldopM;
  logic [31:0] aluM;
  logic [31:0] dmrdM;
  logic [31:0] wpcW;
  logic [4:0]  a3W;
  logic        regwrW;
  logic [31:0] wdW;
  logic        validW;
  logic [31:0] retireCnt;

  typedef struct {
    string       name;
    logic [4:0]  a3;
    logic        regwr;
    logic [31:0] wd;
    logic [31:0] wpc;
    logic        valid;
    logic [31:0] cnt;
  } expT;

  expT         sbQ[$];
  expT         lastExp;
  logic [31:0] expCnt;
  int          compareCount;
  int          failCount;

  mw_writeback_stage #(.PC_RESET(32'h0000_3000), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .valid_m    (validM),
    .pc_m       (pcM),
    .a3_m       (a3M),
    .regwr_m    (regwrM),
    .wdsel_m    (wdselM),
    .ldop_m     (ldopM),
    .alu_m      (aluM),
    .dmrd_m     (dmrdM),
    .wpc_w      (wpcW),
    .a3_w       (a3W),
    .regwr_w    (regwrW),
    .wd_w       (wdW),
    .valid_w    (validW),
    .retire_cnt (retireCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareField(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input expT e);
    compareField(e.name, "a3_w", {27'd0, a3W}, {27'd0, e.a3});
    compareField(e.name, "regwr_w", {31'd0, regwrW}, {31'd0, e.regwr});
    compareField(e.name, "wd_w", wdW, e.wd);
    compareField(e.name, "wpc_w", wpcW, e.wpc);
    compareField(e.name, "valid_w", {31'd0, validW}, {31'd0, e.valid});
    compareField(e.name, "retire_cnt", retireCnt, e.cnt);
  endtask

  // Each stimulus edge queued one expectation; pop exactly one per falling edge.
  always @(negedge clk) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  function automatic logic [31:0] cntModel(input logic rst, input logic e, input logic c, input logic v);
`ifdef WB_RETIRE_CNT_EN
    if (rst) return 32'd0;
    if (e && !c && v) return expCnt + 32'd1;
    return expCnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic applyStimulus(
    input string name, input logic rst, input logic e, input logic c, input logic v,
    input logic [31:0] pc, input logic [4:0] a3, input logic rw, input logic [1:0] sel,
    input logic [2:0] ld, input logic [31:0] alu, input logic [31:0] dm,
    input logic [4:0] eA3, input logic eRegwr, input logic [31:0] eWd,
    input logic [31:0] eWpc, input logic eValid);
    expT x;
    reset = rst; en = e; clr = c; validM = v; pcM = pc; a3M = a3; regwrM = rw;
    wdselM = sel; ldopM = ld; aluM = alu; dmrdM = dm;
    expCnt = cntModel(rst, e, c, v);
    x.name = name; x.a3 = eA3; x.regwr = eRegwr; x.wd = eWd; x.wpc = eWpc;
    x.valid = eValid; x.cnt = expCnt;
    sbQ.push_back(x);
    lastExp = x;
    @(posedge clk);
    #1;
  endtask

  // en low with scrambled M inputs: every W output and the counter must hold.
  task automatic holdStimulus(input string name);
    expT x;
    reset = 1'b0; en = 1'b0; clr = 1'b0; validM = 1'b1; regwrM = 1'b1;
    pcM = $urandom; a3M = 5'($urandom_range(1, 31)); wdselM = 2'($urandom);
    ldopM = 3'($urandom); aluM = $urandom; dmrdM = $urandom;
    x = lastExp;
    x.name = name;
    sbQ.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compareCount = 0;
    failCount    = 0;
    expCnt       = 32'd0;
    reset = 1'b1; en = 1'b0; clr = 1'b0; validM = 1'b0; pcM = 32'd0; a3M = 5'd0;
    regwrM = 1'b0; wdselM = 2'b00; ldopM = 3'b000; aluM = 32'd0; dmrdM = 32'd0;

    applyStimulus("reset", 1, 0, 0, 0, 32'h0, 5'd0, 0, 2'b00, 3'b000, 32'h0, 32'h0,
                  5'd0, 0, 32'h0, 32'h3000, 0);
    applyStimulus("resetOverEn", 1, 1, 0, 1, 32'h4000, 5'd3, 1, 2'b00, 3'b000, 32'h1111, 32'h0,
                  5'd0, 0, 32'h0, 32'h3000, 0);
    applyStimulus("aluWrite", 0, 1, 0, 1, 32'h3004, 5'd8, 1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0,
                  5'd8, 1, 32'hDEAD_BEEF, 32'h3004, 1);
    applyStimulus("lbOff0", 0, 1, 0, 1, 32'h3008, 5'd9, 1, 2'b01, 3'b010, 32'h1000, 32'h80FF_7F01,
                  5'd9, 1, 32'h0000_0001, 32'h3008, 1);
    applyStimulus("lbOff1", 0, 1, 0, 1, 32'h300C, 5'd9, 1, 2'b01, 3'b010, 32'h1001, 32'h80FF_7F01,
                  5'd9, 1, 32'h0000_007F, 32'h300C, 1);
    applyStimulus("lbOff2", 0, 1, 0, 1, 32'h3010, 5'd9, 1, 2'b01, 3'b010, 32'h1002, 32'h80FF_7F01,
                  5'd9, 1, 32'hFFFF_FFFF, 32'h3010, 1);
    applyStimulus("lbOff3", 0, 1, 0, 1, 32'h3014, 5'd9, 1, 2'b01, 3'b010, 32'h1003, 32'h80FF_7F01,
                  5'd9, 1, 32'hFFFF_FF80, 32'h3014, 1);
    applyStimulus("lbuOff3", 0, 1, 0, 1, 32'h3018, 5'd10, 1, 2'b01, 3'b001, 32'h1003, 32'h80FF_7F01,
                  5'd10, 1, 32'h0000_0080, 32'h3018, 1);
    applyStimulus("lhOff2", 0, 1, 0, 1, 32'h301C, 5'd11, 1, 2'b01, 3'b100, 32'h1002, 32'h80FF_7F01,
                  5'd11, 1, 32'hFFFF_80FF, 32'h301C, 1);
    applyStimulus("lhOff3", 0, 1, 0, 1, 32'h3020, 5'd11, 1, 2'b01, 3'b100, 32'h1003, 32'h80FF_7F01,
                  5'd11, 1, 32'hFFFF_80FF, 32'h3020, 1);
    applyStimulus("lhOff0", 0, 1, 0, 1, 32'h3024, 5'd11, 1, 2'b01, 3'b100, 32'h1000, 32'h80FF_7F01,
                  5'd11, 1, 32'h0000_7F01, 32'h3024, 1);
    applyStimulus("lhuOff0", 0, 1, 0, 1, 32'h3028, 5'd12, 1, 2'b01, 3'b011, 32'h1000, 32'h80FF_7F01,
                  5'd12, 1, 32'h0000_7F01, 32'h3028, 1);
    applyStimulus("lhuOff2", 0, 1, 0, 1, 32'h302C, 5'd12, 1, 2'b01, 3'b011, 32'h1002, 32'h80FF_7F01,
                  5'd12, 1, 32'h0000_80FF, 32'h302C, 1);
    applyStimulus("lwOff2", 0, 1, 0, 1, 32'h3030, 5'd13, 1, 2'b01, 3'b000, 32'h1002, 32'h80FF_7F01,
                  5'd13, 1, 32'h80FF_7F01, 32'h3030, 1);
    applyStimulus("ldop5AsLw", 0, 1, 0, 1, 32'h3034, 5'd13, 1, 2'b01, 3'b101, 32'h1001, 32'h1234_5678,
                  5'd13, 1, 32'h1234_5678, 32'h3034, 1);
    applyStimulus("jal", 0, 1, 0, 1, 32'h3010, 5'd31, 1, 2'b10, 3'b000, 32'h0, 32'h0,
                  5'd31, 1, 32'h0000_3018, 32'h3010, 1);
    applyStimulus("jalWrap", 0, 1, 0, 1, 32'hFFFF_FFFC, 5'd31, 1, 2'b10, 3'b000, 32'h0, 32'h0,
                  5'd31, 1, 32'h0000_0004, 32'hFFFF_FFFC, 1);
    applyStimulus("sel11Alu", 0, 1, 0, 1, 32'h3040, 5'd4, 1, 2'b11, 3'b001, 32'hCAFE_F00D, 32'h0,
                  5'd4, 1, 32'hCAFE_F00D, 32'h3040, 1);
    applyStimulus("writeR0", 0, 1, 0, 1, 32'h3044, 5'd0, 1, 2'b00, 3'b000, 32'h0000_1234, 32'h0,
                  5'd0, 0, 32'h0000_1234, 32'h3044, 1);
    applyStimulus("invalidSlot", 0, 1, 0, 0, 32'h3048, 5'd5, 1, 2'b00, 3'b000, 32'h0000_5555, 32'h0,
                  5'd0, 0, 32'h0000_5555, 32'h3048, 0);
    applyStimulus("noRegwr", 0, 1, 0, 1, 32'h304C, 5'd6, 0, 2'b00, 3'b000, 32'h0000_6666, 32'h0,
                  5'd0, 0, 32'h0000_6666, 32'h304C, 1);
    applyStimulus("preHold", 0, 1, 0, 1, 32'h3050, 5'd7, 1, 2'b01, 3'b010, 32'h2003, 32'h80FF_7F01,
                  5'd7, 1, 32'hFFFF_FF80, 32'h3050, 1);
    holdStimulus("hold1");
    holdStimulus("hold2");
    holdStimulus("hold3");
    applyStimulus("clrBubble", 0, 1, 1, 1, 32'h3054, 5'd8, 1, 2'b00, 3'b000, 32'h7777, 32'h0,
                  5'd0, 0, 32'h0, 32'h3000, 0);
    applyStimulus("afterClr", 0, 1, 0, 1, 32'h3058, 5'd9, 1, 2'b00, 3'b000, 32'h8888, 32'h0,
                  5'd9, 1, 32'h0000_8888, 32'h3058, 1);
    applyStimulus("midReset", 1, 1, 0, 1, 32'h305C, 5'd10, 1, 2'b00, 3'b000, 32'h9999, 32'h0,
                  5'd0, 0, 32'h0, 32'h3000, 0);
    applyStimulus("resetOverClr", 1, 1, 1, 1, 32'h3060, 5'd10, 1, 2'b00, 3'b000, 32'h9999, 32'h0,
                  5'd0, 0, 32'h0, 32'h3000, 0);

`ifdef WB_RETIRE_CNT_EN
    @(negedge clk);
    #1;
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    expCnt = 32'hFFFF_FFFF;
    applyStimulus("cntWrap", 0, 1, 0, 1, 32'h3064, 5'd2, 1, 2'b00, 3'b000, 32'h0000_00AA, 32'h0,
                  5'd2, 1, 32'h0000_00AA, 32'h3064, 1);
`endif

    @(negedge clk);
    #1;
    compareCount++;
    if (sbQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
